mem_bus_responder: RTL and testbench
====================================

Name: mem_bus_responder

Overview:
- Target side of the core's data/instruction memory interface.
- Accepts the level-held request the core drives (enable, write, unsigned, width, address, write data) and completes each request after a configurable wait.
- Backed by a word-organised RAM plus a small memory-mapped timer whose compare match drives the core's external interrupt input.
- Reports operation, misalignment and access faults on the same handshake.

Parameters:
RAM_WORDS, 4096, number of 32-bit RAM words mapped from address 0x0000_0000
WAIT_CYCLES, 2, extra cycles between request acceptance and completion (0 allowed)
MMIO_BASE, 32'hFFFF_0000, base of timer registers (mtime at +0, mtimecmp at +4)

Ports:
clk  input  1  clock
reset_n  input  1  reset, asynchronous, active-low
enable  input  1  request valid; held high by the core until busy is low
write  input  1  1 = store, 0 = load
load_unsigned  input  1  1 = zero-extend sub-word loads, 0 = sign-extend
width  input  2  00 byte, 01 half, 10 word, 11 illegal
addr  input  32  byte address
write_data  input  32  store data; low bits used for sub-word stores
read_data  output  32  load result, extended to 32 bits
busy  output  1  request in progress
op_fault  output  1  width == 11
addr_fault  output  1  address misaligned for width
access_fault  output  1  unmapped address, or non-word MMIO access
ext_int  output  1  timer interrupt, high while mtime >= mtimecmp (unsigned)

Behaviour:
- Clock and reset: one clock (clk); reset_n is asynchronous, active-low.
- Reset values: state IDLE; read_data 0; all faults 0; mtime 0; mtimecmp 32'hFFFF_FFFF; ext_int 0. RAM contents are not reset.
- busy = enable & (state != DONE), combinational, so busy is high in the acceptance cycle.
- FSM states: IDLE, WAIT, DONE.
- IDLE & enable:
  - Capture all request inputs.
  - Evaluate faults in priority order: op_fault > addr_fault > access_fault.
  - Any fault: go to DONE next edge, set that single fault flag, leave read_data unchanged, perform no write.
  - No fault, WAIT_CYCLES = 0: go to DONE.
  - No fault, otherwise: go to WAIT with counter = WAIT_CYCLES - 1.
- WAIT: decrement the counter each cycle. At 0, go to DONE. On that edge, commit a store or register the load result into read_data.
- Timing: busy is high for exactly WAIT_CYCLES + 1 cycles for a good request, and exactly 1 cycle for a faulting request.
- DONE: busy 0. Stay while enable is high. Return to IDLE on the first cycle enable is low. A new request needs enable low for at least one cycle.
- Hold rules:
  - read_data holds until the next successful load completes. The core consumes it stages after fetch.
  - Fault flags hold until the next request is accepted; acceptance clears them.
  - Stores do not change read_data.
- Alignment: half requires addr[0] = 0; word requires addr[1:0] = 0.
- Address map:
  - RAM: addr < RAM_WORDS*4, word index = addr[31:2].
  - MMIO: addr == MMIO_BASE or MMIO_BASE+4, width must be word.
  - Everything else is access_fault.
- Little-endian lanes:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Stores write only the selected byte enables.
  - Loads extract the selected lane, then zero- or sign-extend per load_unsigned. A word load ignores load_unsigned.
- Timer:
  - mtime increments every cycle, wrapping 32'hFFFF_FFFF -> 0.
  - A store to mtime at completion replaces the increment that cycle.
  - A store to mtimecmp takes effect the next cycle.
  - ext_int is registered: ext_int(t+1) = (mtime(t) >= mtimecmp(t)).
- Reset mid-request: abort immediately; no RAM or MMIO write; busy follows enable from IDLE.

Test Plan:
- WAIT_CYCLES=2: store word 0xDEADBEEF at 0x10, then load word 0x10 -> busy high 3 cycles each; read_data = 0xDEADBEEF in the DONE cycle; it holds after enable drops.
- Store byte 0x80 at 0x11 over 0x00000000, then load byte 0x11 -> 0xFFFFFF80 with load_unsigned=0, 0x00000080 with load_unsigned=1; load half 0x10 -> 0xFFFF8000 (signed).
- Faults:
  - width=11 -> op_fault only, busy 1 cycle.
  - Half at 0x13 -> addr_fault.
  - Word at RAM_WORDS*4 -> access_fault.
  - Byte at MMIO_BASE -> access_fault.
  - Each fault leaves RAM and read_data unchanged.
- Store mtimecmp = 50 after reset, count cycles -> ext_int rises exactly one cycle after mtime reaches 50. Store mtimecmp = 0xFFFF_FFFF -> ext_int falls; read mtime returns a monotonically increasing value.
- Assert reset_n low during WAIT of a store to 0x20 -> RAM[8] unchanged; state IDLE; busy = enable; faults 0.
- WAIT_CYCLES=0: back-to-back fetch-style loads with enable low for one cycle between -> each busy pulse is 1 cycle; the second request is not accepted while enable stays high in DONE.

Source files
------------

// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - memory-bus target: word RAM plus mtime/mtimecmp timer, configurable wait
// Requests are sampled live in IDLE and from the captured copy afterwards, so the zero-wait path shares the commit logic.
module mem_bus_responder #(
  parameter int          RAM_WORDS   = 4096,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        write,
  input  logic        load_unsigned,
  input  logic [1:0]  width,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        busy,
  output logic        op_fault,
  output logic        addr_fault,
  output logic        access_fault,
  output logic        ext_int
);
  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_LIMIT = 32'(RAM_WORDS * 4);
  localparam int          CW        = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          req_write, req_uns;
  logic [1:0]    req_width;
  logic [31:0]   req_addr, req_wdata;
  logic [31:0]   mtime, mtimecmp;
  logic [31:0]   mem [RAM_WORDS];

  logic          cur_write, cur_uns;
  logic [1:0]    cur_width;
  logic [31:0]   cur_addr, cur_wdata;
  logic          is_ram, is_mtime, is_mtimecmp;
  logic          f_op, f_addr, f_acc, any_fault, accept, commit;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word, load_val, wr_lanes;
  logic [7:0]    lane_byte;
  logic [15:0]   lane_half;
  logic [3:0]    be;

  always_comb begin
    cur_write = req_write;
    cur_uns   = req_uns;
    cur_width = req_width;
    cur_addr  = req_addr;
    cur_wdata = req_wdata;
    if (state == IDLE) begin
      cur_write = write;
      cur_uns   = load_unsigned;
      cur_width = width;
      cur_addr  = addr;
      cur_wdata = write_data;
    end
  end

  assign is_ram      = cur_addr < RAM_LIMIT;
  assign is_mtime    = cur_addr == MMIO_BASE;
  assign is_mtimecmp = cur_addr == MMIO_BASE + 32'd4;
  assign f_op        = cur_width == 2'b11;
  assign f_addr      = (cur_width == 2'b01 && cur_addr[0]) ||
                       (cur_width == 2'b10 && cur_addr[1:0] != 2'b00);
  assign f_acc       = !(is_ram || ((is_mtime || is_mtimecmp) && cur_width == 2'b10));
  assign any_fault   = f_op | f_addr | f_acc;
  assign accept      = (state == IDLE) && enable;
  assign commit      = (accept && !any_fault && WAIT_CYCLES == 0) ||
                       (state == WAIT && cnt == '0);
  assign busy        = enable && (state != DONE);
  assign idx         = cur_addr[AW+1:2];

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: if (enable) begin
        if (any_fault || WAIT_CYCLES == 0) state_n = DONE;
        else begin
          state_n = WAIT;
          cnt_n   = CW'(WAIT_CYCLES - 1);
        end
      end
      WAIT: if (cnt == '0) state_n = DONE;
            else cnt_n = cnt - 1'b1;
      DONE: if (!enable) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Lane extraction and store byte enables, little-endian
  always_comb begin
    rd_word   = is_ram ? mem[idx] : (is_mtime ? mtime : mtimecmp);
    lane_byte = rd_word[{cur_addr[1:0], 3'b000} +: 8];
    lane_half = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];
    load_val  = rd_word;
    be        = 4'b1111;
    wr_lanes  = cur_wdata;
    case (cur_width)
      2'b00: begin
        load_val = {{24{~cur_uns & lane_byte[7]}}, lane_byte};
        be       = 4'b0001 << cur_addr[1:0];
        wr_lanes = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        load_val = {{16{~cur_uns & lane_half[15]}}, lane_half};
        be       = cur_addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{cur_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n && commit && cur_write && is_ram) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wr_lanes[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      req_write    <= 1'b0;
      req_uns      <= 1'b0;
      req_width    <= 2'b00;
      req_addr     <= '0;
      req_wdata    <= '0;
      read_data    <= '0;
      op_fault     <= 1'b0;
      addr_fault   <= 1'b0;
      access_fault <= 1'b0;
      mtime        <= '0;
      mtimecmp     <= 32'hFFFF_FFFF;
      ext_int      <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      ext_int <= mtime >= mtimecmp;
      if (commit && cur_write && is_mtime) mtime <= cur_wdata;
      else                                 mtime <= mtime + 32'd1;
      if (commit && cur_write && is_mtimecmp) mtimecmp <= cur_wdata;
      if (accept) begin
        req_write    <= write;
        req_uns      <= load_unsigned;
        req_width    <= width;
        req_addr     <= addr;
        req_wdata    <= write_data;
        op_fault     <= f_op;
        addr_fault   <= !f_op && f_addr;
        access_fault <= !f_op && !f_addr && f_acc;
      end
      if (commit && !cur_write) read_data <= load_val;
    end
  end
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - directed self-checking bench for mem_bus_responder
module tb_mem_bus_responder;
  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset_n, enable, write, load_unsigned;
  logic [1:0]  width;
  logic [31:0] addr, write_data;
  logic [31:0] read_data, read_data0;
  logic        busy, op_fault, addr_fault, access_fault, ext_int;
  logic        busy0, op_fault0, addr_fault0, access_fault0, ext_int0;
  int          passed = 0, total = 0;
  int          n;
  logic [31:0] v1, v2;
  int          hits;

  always #5 clk = ~clk;

  mem_bus_responder #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .write(write),
    .load_unsigned(load_unsigned), .width(width), .addr(addr), .write_data(write_data),
    .read_data(read_data), .busy(busy), .op_fault(op_fault), .addr_fault(addr_fault),
    .access_fault(access_fault), .ext_int(ext_int));

  mem_bus_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .write(write),
    .load_unsigned(load_unsigned), .width(width), .addr(addr), .write_data(write_data),
    .read_data(read_data0), .busy(busy0), .op_fault(op_fault0), .addr_fault(addr_fault0),
    .access_fault(access_fault0), .ext_int(ext_int0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Starts just after a posedge; returns at the first negedge with busy low (DONE)
  task automatic req(input bit sel, input logic wr, input logic uns, input logic [1:0] wd,
                     input logic [31:0] a, input logic [31:0] d, output int cycles);
    write = wr; load_unsigned = uns; width = wd; addr = a; write_data = d; enable = 1'b1;
    cycles = 0;
    @(negedge clk);
    while ((sel ? busy0 : busy) && cycles < 20) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic rel();
    @(posedge clk); #1 enable = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] flt();
    return {29'b0, op_fault, addr_fault, access_fault};
  endfunction

  initial begin
    reset_n = 1'b0; enable = 1'b0; write = 1'b0; load_unsigned = 1'b0;
    width = 2'b00; addr = '0; write_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_faults", flt(), 32'h0);
    chk("rst_ext_int", {31'b0, ext_int}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    @(posedge clk); #1 reset_n = 1'b1;

    // mtime is 3 after the commit edge of this store; 47 more edges bring it to 50
    req(0, 1, 0, 2'b10, MB + 4, 32'd50, n);
    chk("cmp_store_busy", n, 3);
    repeat (47) @(negedge clk);
    chk("ext_int_at_50", {31'b0, ext_int}, 32'h0);
    @(negedge clk);
    chk("ext_int_at_51", {31'b0, ext_int}, 32'h1);
    rel();
    req(0, 1, 0, 2'b10, MB + 4, 32'hFFFF_FFFF, n);
    rel();
    chk("ext_int_fall", {31'b0, ext_int}, 32'h0);
    req(0, 0, 0, 2'b10, MB, 32'h0, n);
    v1 = read_data;
    rel();
    req(0, 0, 0, 2'b10, MB, 32'h0, n);
    v2 = read_data;
    rel();
    chk("mtime_gt50", {31'b0, v1 > 32'd50}, 32'h1);
    chk("mtime_mono", {31'b0, v2 > v1}, 32'h1);

    req(0, 1, 0, 2'b10, 32'h10, 32'hDEAD_BEEF, n);
    chk("sw_busy", n, 3);
    rel();
    req(0, 0, 0, 2'b10, 32'h10, 32'h0, n);
    chk("lw_busy", n, 3);
    chk("lw_data", read_data, 32'hDEAD_BEEF);
    rel();
    chk("lw_hold", read_data, 32'hDEAD_BEEF);

    req(0, 1, 0, 2'b10, 32'h10, 32'h0, n); rel();
    req(0, 1, 0, 2'b00, 32'h11, 32'h0000_0080, n); rel();
    req(0, 0, 0, 2'b00, 32'h11, 32'h0, n);
    chk("lb_signed", read_data, 32'hFFFF_FF80);
    rel();
    req(0, 0, 1, 2'b00, 32'h11, 32'h0, n);
    chk("lbu", read_data, 32'h0000_0080);
    rel();
    req(0, 0, 0, 2'b01, 32'h10, 32'h0, n);
    chk("lh_signed", read_data, 32'hFFFF_8000);
    rel();

    req(0, 0, 0, 2'b11, 32'h13, 32'h0, n);
    chk("op_busy", n, 1);
    chk("op_flags", flt(), 32'h4);
    chk("op_rd_hold", read_data, 32'hFFFF_8000);
    rel();
    req(0, 1, 0, 2'b01, 32'h13, 32'hFFFF, n);
    chk("align_busy", n, 1);
    chk("align_flags", flt(), 32'h2);
    rel();
    req(0, 1, 0, 2'b10, 32'h4000, 32'h5555_5555, n);
    chk("ram_oob_flags", flt(), 32'h1);
    rel();
    req(0, 1, 0, 2'b00, MB, 32'h0, n);
    chk("mmio_byte_flags", flt(), 32'h1);
    chk("fault_rd_hold", read_data, 32'hFFFF_8000);
    rel();
    req(0, 0, 0, 2'b10, 32'h10, 32'h0, n);
    chk("ram_after_faults", read_data, 32'h0000_8000);
    chk("flags_cleared", flt(), 32'h0);
    rel();

    req(0, 1, 0, 2'b10, 32'h20, 32'h1111_1111, n); rel();
    write = 1'b1; width = 2'b10; addr = 32'h20; write_data = 32'h2222_2222; enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_busy_hi", {31'b0, busy}, 32'h1);
    chk("rst_mid_faults", flt(), 32'h0);
    chk("rst_mid_rd", read_data, 32'h0);
    enable = 1'b0;
    #1;
    chk("rst_mid_busy_lo", {31'b0, busy}, 32'h0);
    @(posedge clk); #1 reset_n = 1'b1;
    req(0, 0, 0, 2'b10, 32'h20, 32'h0, n);
    chk("rst_mid_ram", read_data, 32'h1111_1111);
    rel();

    req(1, 1, 0, 2'b10, 32'h40, 32'h1234_5678, n);
    chk("w0_store_busy", n, 1);
    rel();
    req(1, 0, 0, 2'b10, 32'h40, 32'h0, n);
    chk("w0_load_busy", n, 1);
    chk("w0_load_data", read_data0, 32'h1234_5678);
    hits = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy0) hits++;
    end
    chk("w0_no_reaccept", hits, 0);
    rel();
    req(1, 0, 1, 2'b01, 32'h42, 32'h0, n);
    chk("w0_second_busy", n, 1);
    chk("w0_second_data", read_data0, 32'h0000_1234);
    rel();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
